// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: priority state encoding and memory geometry.
package dm_arb_pkg;

   typedef enum logic {
      PRIO_M0 = 1'b0,
      PRIO_M1 = 1'b1
   } prio_t;

   localparam int unsigned DM_WORDS = 3072;
   localparam int unsigned DM_BYTES = 4 * DM_WORDS;

endpackage

// File: rtl/dm_addr_check.sv
// Combinational legality check for one data-memory access: flags misaligned or out-of-range byte addresses.
module dm_addr_check
   import dm_arb_pkg::*;
#(
   parameter int unsigned DM_WORDS = dm_arb_pkg::DM_WORDS
) (
   input  logic [31:0] addr,
   output logic        err
);

   localparam logic [31:0] LIMIT = 32'(4 * DM_WORDS);

   assign err = (addr[1:0] != 2'b00) || (addr >= LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory: core priority with a starvation guard,
// address checking and one-cycle registered responses. Optional trace: define DM_ARB_TRACE_EN.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned DM_WORDS   = dm_arb_pkg::DM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m0_pc,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [31:0] m1_pc,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        dm_WE,
   output logic        dm_RE,
   output logic [31:0] dm_A,
   output logic [31:0] dm_WD,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_RD
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   prio_t       state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        err0, err1;
   logic        any_gnt, sel_we, sel_err;
   logic [31:0] sel_addr, sel_wdata, sel_pc;

   dm_addr_check #(.DM_WORDS(DM_WORDS)) u_chk0 (.addr(m0_addr), .err(err0));
   dm_addr_check #(.DM_WORDS(DM_WORDS)) u_chk1 (.addr(m1_addr), .err(err1));

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!reset) begin
         unique case (state)
            PRIO_M0: begin
               if (m0_req) begin
                  m0_gnt = 1'b1;
                  if (m1_req) begin
                     if (cnt + 4'd1 == STARVE_LIM) begin
                        state_nxt = PRIO_M1;
                        cnt_nxt   = 4'd0;
                     end else begin
                        cnt_nxt = cnt + 4'd1;
                     end
                  end
               end else if (m1_req) begin
                  m1_gnt  = 1'b1;
                  cnt_nxt = 4'd0;
               end
            end
            PRIO_M1: begin
               if (m1_req) begin
                  m1_gnt    = 1'b1;
                  state_nxt = PRIO_M0;
               end else if (m0_req) begin
                  m0_gnt = 1'b1;
               end
            end
            default: state_nxt = PRIO_M0;
         endcase
      end
   end

   // Selected master's fields; an erroneous access is granted but never reaches the memory.
   always_comb begin
      any_gnt   = m0_gnt | m1_gnt;
      sel_we    = m1_gnt ? m1_we    : m0_we;
      sel_err   = m1_gnt ? err1     : err0;
      sel_addr  = m1_gnt ? m1_addr  : m0_addr;
      sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
      sel_pc    = m1_gnt ? m1_pc    : m0_pc;
      dm_WE     = any_gnt & sel_we & ~sel_err;
      dm_RE     = any_gnt & ~sel_we & ~sel_err;
      dm_A      = any_gnt ? sel_addr  : 32'd0;
      dm_WD     = any_gnt ? sel_wdata : 32'd0;
      dm_pc     = any_gnt ? sel_pc    : 32'd0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PRIO_M0;
         cnt       <= 4'd0;
         m0_rvalid <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rvalid <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= 32'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         m0_rvalid <= m0_gnt;
         m0_err    <= m0_gnt & err0;
         m0_rdata  <= (m0_gnt & ~m0_we & ~err0) ? dm_RD : 32'd0;
         m1_rvalid <= m1_gnt;
         m1_err    <= m1_gnt & err1;
         m1_rdata  <= (m1_gnt & ~m1_we & ~err1) ? dm_RD : 32'd0;
      end
   end

`ifdef DM_ARB_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && any_gnt)
         $display("@%h: arb m%0d %s *%h", sel_pc, m1_gnt ? 1 : 0,
                  sel_err ? "E" : (sel_we ? "W" : "R"), sel_addr);
   end
`else
   // Trace disabled: this block produces no simulation output.
`endif

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: m0 (CPU core load/store port) and m1 (debug/loader master).
- Sits between the requesters and the data memory and drives its WE/RE/A/WD/pc inputs.
- Uses fixed core priority with a starvation guard, so m1 always makes progress.
- Also range- and alignment-checks every access and returns registered read data with a valid pulse.

Parameters:
- STARVE_MAX, 4: consecutive contested cycles m0 may win before m1 is forced through (legal range 1..15).
- DM_WORDS, 3072: data-memory depth in words; legal byte addresses are 0 .. 4*DM_WORDS-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- m0_req  input  1  core access request
- m0_we  input  1  1 = store, 0 = load
- m0_addr  input  32  byte address
- m0_wdata  input  32  store data
- m0_pc  input  32  PC of the requesting instruction (passed to DM display)
- m0_gnt  output  1  access accepted this cycle
- m0_rvalid  output  1  response valid, one cycle after gnt
- m0_rdata  output  32  load data (0 for stores and errors)
- m0_err  output  1  out-of-range or misaligned; qualified by m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_pc, m1_gnt, m1_rvalid, m1_rdata, m1_err: same meanings, for m1
- dm_WE  output  1  DM write enable
- dm_RE  output  1  DM read enable
- dm_A  output  32  DM byte address
- dm_WD  output  32  DM write data
- dm_pc  output  32  PC forwarded to DM
- dm_RD  input  32  DM combinational read data

Behaviour:
- Grant is combinational in the request cycle; the selected master's fields are muxed onto dm_*.
- The unselected master sees gnt=0 and must hold its request stable until granted.
- Only the granted access drives dm_WE/dm_RE; with no grant: dm_WE=dm_RE=0, dm_A=dm_WD=dm_pc=0.
- Error check, per request: err if addr[1:0]!=0 or addr >= 4*DM_WORDS.
  - An erroneous access is still granted, but dm_WE/dm_RE are forced 0.
  - In the next cycle it returns rvalid=1, err=1, rdata=0.
- Response latency: exactly 1 cycle.
  - The cycle after gnt, that master's rvalid=1.
  - rdata = registered dm_RD for loads, 0 for stores.
  - err is registered.
  - rvalid is a single-cycle pulse per grant; back-to-back grants give back-to-back rvalids.
- Priority FSM, states PRIO_M0 (reset state) and PRIO_M1, plus a 4-bit contested-cycle counter cnt:
  - PRIO_M0, only m0 requests: grant m0, cnt unchanged.
  - PRIO_M0, only m1 requests: grant m1, cnt<=0.
  - PRIO_M0, both request: grant m0, cnt<=cnt+1. If cnt+1==STARVE_MAX: go to PRIO_M1 and set cnt<=0.
  - PRIO_M1, m1 requests (contested or not): grant m1, go to PRIO_M0.
  - PRIO_M1, only m0 requests: grant m0, stay in PRIO_M1.
  - Neither requests: no grant, state and cnt hold.
- Reset behaviour:
  - All outputs 0, state PRIO_M0, cnt 0, rdata registers 0.
  - While reset=1, no grants are issued and dm_WE=0.
  - A grant in the cycle reset asserts produces no rvalid.

Optional Feature:
- Macro DM_ARB_TRACE_EN.
- Defined: on every granted clock edge outside reset, print "@%h: arb m%0d %s *%h" with pc, master, "W"/"R"/"E", addr. Errors print as "E".
- Undefined: no simulation output from this block; RTL behaviour is identical either way.

Decomposition:
- Shared package dm_arb_pkg holds:
  - state encodings PRIO_M0=1'b0, PRIO_M1=1'b1;
  - DM_WORDS default 3072;
  - DM_BYTES = 4*DM_WORDS.
- One natural sub-module, dm_addr_check: combinational addr -> err. It is instantiated twice (once per master).

Test Plan:
1. m0 store 0x0000_0010 <= 0xDEADBEEF, then m0 load 0x10 -> m0_gnt both cycles; load gives m0_rvalid=1, m0_rdata=0xDEADBEEF, err=0 one cycle later.
2. m0 and m1 both request continuously, STARVE_MAX=4 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1; m1 is never starved beyond 4 cycles.
3. m1 alone loads 0x0000_2FFC -> granted, valid data returned; m1 loads 0x0000_3000 -> m1_err=1, m1_rdata=0, dm_RE=0.
4. m0 stores to misaligned 0x0000_0006 -> m0_err=1 next cycle; dm_WE stays 0 and a subsequent read of word 0x4 is unchanged.
5. Both requesting with cnt=3; reset asserted for 1 cycle -> no gnt/rvalid that cycle; after release m0 wins the next 4 contested cycles (state PRIO_M0, cnt 0).
6. Idle for 5 cycles, then single m1 request -> immediate m1_gnt; cnt is cleared and the state stays PRIO_M0.
